// File: rtl/px_upsampler.sv
// Nearest-neighbour AXI4-Stream upscaler: replicates pixels px_rep times and lines ln_rep times.
// Define PX_UPSAMPLER_STATS_EN to add the out_lines_o / overflow_o frame statistics.
module px_upsampler #(
    parameter int PX_WIDTH     = 30,
    parameter int FRAME_RES_X  = 1920,
    parameter int MAX_REP      = 8,
    localparam int TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8,
    localparam int FW          = $clog2(MAX_REP + 1),
    localparam int PW          = $clog2(FRAME_RES_X) + 1,
    localparam int AW          = $clog2(FRAME_RES_X)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [FW-1:0]            px_rep_i,
    input  logic [FW-1:0]            ln_rep_i,
    input  logic [TDATA_WIDTH-1:0]   video_i_tdata,
    input  logic                     video_i_tvalid,
    output logic                     video_i_tready,
    input  logic                     video_i_tuser,
    input  logic                     video_i_tlast,
    output logic [TDATA_WIDTH-1:0]   video_o_tdata,
    output logic                     video_o_tvalid,
    input  logic                     video_o_tready,
    output logic                     video_o_tuser,
    output logic                     video_o_tlast,
    output logic [TDATA_WIDTH/8-1:0] video_o_tkeep,
    output logic [TDATA_WIDTH/8-1:0] video_o_tstrb,
    output logic                     video_o_tid,
    output logic                     video_o_tdest
`ifdef PX_UPSAMPLER_STATS_EN
    ,
    output logic [15:0]              out_lines_o,
    output logic                     overflow_o
`endif
);

    typedef enum logic [1:0] {RX_LINE_S, REPLAY_S, LAST_S} state_t;

    function automatic logic [FW-1:0] sat_rep(input logic [FW-1:0] r);
        if (r == '0)
            return FW'(1);
        if (r > FW'(MAX_REP))
            return FW'(MAX_REP);
        return r;
    endfunction

    state_t                 state;
    logic [FW-1:0]          px_rep, ln_rep, copy_cnt, ln_cnt;
    logic                   hold_valid, hold_sof, hold_eol;
    logic [TDATA_WIDTH-1:0] hold_data, rd_q;
    logic [PW-1:0]          wr_ptr, rd_ptr, line_len, wr_base;
    logic [TDATA_WIDTH-1:0] mem [FRAME_RES_X];

    logic in_hs, in_sof, out_hs, last_copy, wr_ok, rd_en;
    logic [AW-1:0] rd_addr;

    assign in_hs     = video_i_tvalid && video_i_tready;
    assign in_sof    = in_hs && video_i_tuser;
    assign out_hs    = video_o_tvalid && video_o_tready;
    assign last_copy = copy_cnt == px_rep - FW'(1);
    // A SOF restarts the line even if the previous one never saw EOL
    assign wr_base   = video_i_tuser ? '0 : wr_ptr;
    assign wr_ok     = wr_base < PW'(FRAME_RES_X);

    // Hold back the next line while the EOL pixel's last copy hands over to a replay
    assign video_i_tready = !rst_i && state == RX_LINE_S &&
        (!hold_valid || (video_o_tready && last_copy && !(hold_eol && ln_rep > FW'(1))));

    assign video_o_tvalid = hold_valid;
    assign video_o_tdata  = (state == REPLAY_S) ? rd_q : hold_data;
    assign video_o_tuser  = hold_valid && state == RX_LINE_S && hold_sof && copy_cnt == '0;
    assign video_o_tlast  = hold_valid && last_copy &&
                            ((state == REPLAY_S) ? rd_ptr == line_len : hold_eol);
    assign video_o_tkeep  = '1;
    assign video_o_tstrb  = '1;
    assign video_o_tid    = 1'b0;
    assign video_o_tdest  = 1'b0;

    // Next word is fetched while the last copy of the current one is handed over
    assign rd_en   = (state == LAST_S) ||
                     (state == REPLAY_S && out_hs && last_copy && rd_ptr != line_len);
    assign rd_addr = (state == LAST_S) ? '0 : rd_ptr[AW-1:0];

    always_ff @(posedge clk_i) begin
        if (in_hs && wr_ok)
            mem[wr_base[AW-1:0]] <= video_i_tdata;
        if (rd_en)
            rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= RX_LINE_S;
            px_rep     <= FW'(1);
            ln_rep     <= FW'(1);
            copy_cnt   <= '0;
            ln_cnt     <= '0;
            hold_valid <= 1'b0;
            hold_sof   <= 1'b0;
            hold_eol   <= 1'b0;
            hold_data  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            line_len   <= '0;
        end else begin
            if (in_sof) begin
                px_rep <= sat_rep(px_rep_i);
                ln_rep <= sat_rep(ln_rep_i);
            end
            if (in_hs) begin
                wr_ptr <= video_i_tlast ? '0 : (wr_ok ? wr_base + PW'(1) : wr_base);
                if (video_i_tlast)
                    line_len <= wr_ok ? wr_base + PW'(1) : PW'(FRAME_RES_X);
            end
            case (state)
                RX_LINE_S: begin
                    if (in_hs) begin
                        hold_valid <= 1'b1;
                        hold_data  <= video_i_tdata;
                        hold_sof   <= video_i_tuser;
                        hold_eol   <= video_i_tlast;
                        copy_cnt   <= '0;
                    end else if (out_hs) begin
                        if (!last_copy) begin
                            copy_cnt <= copy_cnt + FW'(1);
                        end else begin
                            hold_valid <= 1'b0;
                            copy_cnt   <= '0;
                            if (hold_eol && ln_rep > FW'(1)) begin
                                state  <= LAST_S;
                                ln_cnt <= '0;
                            end
                        end
                    end
                    if (in_sof)
                        ln_cnt <= '0;
                end
                LAST_S: begin
                    state      <= REPLAY_S;
                    hold_valid <= 1'b1;
                    copy_cnt   <= '0;
                    rd_ptr     <= PW'(1);
                end
                REPLAY_S: begin
                    if (out_hs) begin
                        if (!last_copy) begin
                            copy_cnt <= copy_cnt + FW'(1);
                        end else begin
                            copy_cnt <= '0;
                            if (rd_ptr == line_len) begin
                                hold_valid <= 1'b0;
                                ln_cnt     <= ln_cnt + FW'(1);
                                state      <= (ln_cnt + FW'(1) == ln_rep - FW'(1)) ? RX_LINE_S : LAST_S;
                            end else begin
                                rd_ptr <= rd_ptr + PW'(1);
                            end
                        end
                    end
                end
                default: state <= RX_LINE_S;
            endcase
        end
    end

`ifdef PX_UPSAMPLER_STATS_EN
    logic [15:0] line_cnt;
    logic        out_eol;

    assign out_eol = out_hs && video_o_tlast;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            line_cnt    <= '0;
            out_lines_o <= '0;
            overflow_o  <= 1'b0;
        end else begin
            if (in_sof) begin
                out_lines_o <= line_cnt + (out_eol ? 16'd1 : 16'd0);
                line_cnt    <= '0;
            end else if (out_eol) begin
                line_cnt <= line_cnt + 16'd1;
            end
            if (in_hs && !wr_ok)
                overflow_o <= 1'b1;
            else if (in_sof)
                overflow_o <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_px_upsampler.sv
// Bench for px_upsampler: frame-level replication model, directed frames, per-beat scoreboard.
module tb_px_upsampler;
    localparam int FRX  = 8;
    localparam int MAXR = 8;
    localparam int TW   = 32;
    localparam int FW   = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [FW-1:0] px_rep_i = '0, ln_rep_i = '0;
    logic [TW-1:0] video_i_tdata = '0;
    logic          video_i_tvalid = 1'b0, video_i_tuser = 1'b0, video_i_tlast = 1'b0;
    logic          video_i_tready;
    logic [TW-1:0] video_o_tdata;
    logic          video_o_tvalid, video_o_tuser, video_o_tlast;
    logic          video_o_tready = 1'b1;
    logic [3:0]    video_o_tkeep, video_o_tstrb;
    logic          video_o_tid, video_o_tdest;
`ifdef PX_UPSAMPLER_STATS_EN
    logic [15:0]   out_lines_o;
    logic          overflow_o;
`endif

    px_upsampler #(.PX_WIDTH(30), .FRAME_RES_X(FRX), .MAX_REP(MAXR)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .px_rep_i(px_rep_i), .ln_rep_i(ln_rep_i),
        .video_i_tdata(video_i_tdata), .video_i_tvalid(video_i_tvalid),
        .video_i_tready(video_i_tready), .video_i_tuser(video_i_tuser),
        .video_i_tlast(video_i_tlast), .video_o_tdata(video_o_tdata),
        .video_o_tvalid(video_o_tvalid), .video_o_tready(video_o_tready),
        .video_o_tuser(video_o_tuser), .video_o_tlast(video_o_tlast),
        .video_o_tkeep(video_o_tkeep), .video_o_tstrb(video_o_tstrb),
        .video_o_tid(video_o_tid), .video_o_tdest(video_o_tdest)
`ifdef PX_UPSAMPLER_STATS_EN
        , .out_lines_o(out_lines_o), .overflow_o(overflow_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic [31:0] d; bit u; bit l; bit rs; } beat_t;
    beat_t exp_q[$];
    beat_t b;
    int total = 0, bad = 0, cyc = 0, beats = 0, last_hs = 0, in_sof_cyc = 0;
    bit rnd_rdy = 1'b0, stall_q = 1'b0;
    logic [34:0] stall_v;

    initial forever begin @(posedge clk_i); cyc++; end
    initial forever begin
        @(posedge clk_i); #1;
        video_o_tready = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, expv, $time);
        end
    endtask

    function automatic int eff(input int r);
        return (r == 0) ? 1 : ((r > MAXR) ? MAXR : r);
    endfunction

    // Expected output of one frame: every line shown ln times, replays clipped to FRX pixels
    task automatic model_frame(input int nl, input int ll, input int base, input int px, input int ln);
        int p, n, len;
        beat_t e;
        p = eff(px);
        n = eff(ln);
        for (int l = 0; l < nl; l++)
            for (int r = 0; r < n; r++) begin
                len = (r == 0) ? ll : ((ll > FRX) ? FRX : ll);
                for (int i = 0; i < len; i++)
                    for (int c = 0; c < p; c++) begin
                        e.d  = 32'(base + l * ll + i);
                        e.u  = (l == 0 && r == 0 && i == 0 && c == 0);
                        e.l  = (i == len - 1 && c == p - 1);
                        e.rs = (r > 0 && i == 0 && c == 0);
                        exp_q.push_back(e);
                    end
            end
    endtask

    always @(negedge clk_i) begin
        if (rst_i) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q)
                chk("stable", {video_o_tvalid, video_o_tuser, video_o_tlast, video_o_tdata}, stall_v);
            if (video_i_tvalid && video_i_tready && video_i_tuser)
                in_sof_cyc = cyc;
            if (video_o_tvalid && video_o_tready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat got=%0h exp=none t=%0t", video_o_tdata, $time);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat", {video_o_tuser, video_o_tlast, video_o_tdata}, {b.u, b.l, b.d});
                    if (!rnd_rdy && b.rs)
                        chk("bubble", 64'(cyc - last_hs), 2);
                    if (!rnd_rdy && b.u)
                        chk("latency", 64'(cyc - in_sof_cyc), 1);
                end
                last_hs = cyc;
            end
            stall_q = video_o_tvalid && !video_o_tready;
            stall_v = {video_o_tvalid, video_o_tuser, video_o_tlast, video_o_tdata};
        end
    end

    task automatic drive_line(input int ll, input int base, input bit sof, input bit rnd);
        int n;
        for (int i = 0; i < ll; i++) begin
            if (rnd)
                while ($urandom_range(1) == 0) begin
                    video_i_tvalid = 1'b0;
                    @(posedge clk_i); #1;
                end
            video_i_tdata  = 32'(base + i);
            video_i_tuser  = sof && (i == 0);
            video_i_tlast  = (i == ll - 1);
            video_i_tvalid = 1'b1;
            n = 0;
            @(negedge clk_i);
            while (!video_i_tready && n < 2000) begin
                n++;
                @(negedge clk_i);
            end
            if (n >= 2000) begin
                total++;
                bad++;
                $display("FAIL in_timeout got=tready0 exp=handshake t=%0t", $time);
                video_i_tvalid = 1'b0;
                return;
            end
            @(posedge clk_i); #1;
        end
        video_i_tvalid = 1'b0;
        video_i_tuser  = 1'b0;
        video_i_tlast  = 1'b0;
    endtask

    task automatic wait_done(input int exp_n, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        repeat (4) @(negedge clk_i);
        chk("drain", 64'(exp_q.size()), 0);
        chk("beats", 64'(beats), 64'(exp_n));
        exp_q.delete();
        beats = 0;
        @(posedge clk_i); #1;
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk("rst_tvalid", video_o_tvalid, 0);
        chk("rst_tdata", video_o_tdata, 0);
        chk("rst_tuser_tlast", {video_o_tuser, video_o_tlast}, 0);
        chk("rst_i_tready", video_i_tready, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("tkeep_tstrb", {video_o_tkeep, video_o_tstrb}, 8'hFF);
        chk("tid_tdest", {video_o_tid, video_o_tdest}, 0);

        // 2/2 on a 4x2 frame, data 1..8
        px_rep_i = 4'd2; ln_rep_i = 4'd2;
        model_frame(2, 4, 1, 2, 2);
        chk("m_len", 64'(exp_q.size()), 32);
        chk("m_b0", {exp_q[0].u, exp_q[0].d}, {1'b1, 32'd1});
        chk("m_b3", exp_q[3].d, 2);
        chk("m_b7", {exp_q[7].l, exp_q[7].d}, {1'b1, 32'd4});
        chk("m_b8", {exp_q[8].rs, exp_q[8].u, exp_q[8].d}, {1'b1, 1'b0, 32'd1});
        chk("m_b16", exp_q[16].d, 5);
        chk("m_b31", {exp_q[31].l, exp_q[31].d}, {1'b1, 32'd8});
        drive_line(4, 1, 1'b1, 1'b0);
        drive_line(4, 5, 1'b0, 1'b0);
        wait_done(32, 500);

        // Pass-through with 1/1 and with 0/0
        px_rep_i = 4'd1; ln_rep_i = 4'd1;
        model_frame(3, 3, 20, 1, 1);
        for (int l = 0; l < 3; l++) drive_line(3, 20 + 3 * l, l == 0, 1'b0);
        wait_done(9, 300);
        px_rep_i = 4'd0; ln_rep_i = 4'd0;
        model_frame(3, 3, 30, 0, 0);
        for (int l = 0; l < 3; l++) drive_line(3, 30 + 3 * l, l == 0, 1'b0);
        wait_done(9, 300);

        // 3/4 with random backpressure and random input gaps
        rnd_rdy = 1'b1;
        px_rep_i = 4'd3; ln_rep_i = 4'd4;
        model_frame(3, 4, 40, 3, 4);
        for (int l = 0; l < 3; l++) drive_line(4, 40 + 4 * l, l == 0, 1'b1);
        wait_done(144, 3000);
        rnd_rdy = 1'b0;
        @(posedge clk_i); #1;

        // Factor ports change mid-frame; only the next SOF picks them up
        px_rep_i = 4'd2; ln_rep_i = 4'd2;
        model_frame(2, 3, 60, 2, 2);
        model_frame(2, 2, 70, 3, 1);
        drive_line(3, 60, 1'b1, 1'b0);
        px_rep_i = 4'd3; ln_rep_i = 4'd1;
        drive_line(3, 63, 1'b0, 1'b0);
        drive_line(2, 70, 1'b1, 1'b0);
        drive_line(2, 72, 1'b0, 1'b0);
        wait_done(24 + 12, 600);

        // 10-pixel line into an 8-deep buffer
        px_rep_i = 4'd1; ln_rep_i = 4'd2;
        model_frame(1, 10, 300, 1, 2);
        drive_line(10, 300, 1'b1, 1'b0);
        wait_done(18, 300);
`ifdef PX_UPSAMPLER_STATS_EN
        chk("overflow_set", overflow_o, 1);
`endif

        // One-pixel frame (SOF and EOL on one beat), saturating factor above MAX_REP
        px_rep_i = 4'd3; ln_rep_i = 4'd2;
        model_frame(1, 1, 400, 3, 2);
        drive_line(1, 400, 1'b1, 1'b0);
        wait_done(6, 200);
        px_rep_i = 4'd15; ln_rep_i = 4'd1;
        model_frame(1, 2, 410, 15, 1);
        drive_line(2, 410, 1'b1, 1'b0);
        wait_done(16, 300);
`ifdef PX_UPSAMPLER_STATS_EN
        chk("out_lines", out_lines_o, 2);
        chk("overflow_clr", overflow_o, 0);
`endif

        // Reset in the middle of a replayed line
        px_rep_i = 4'd1; ln_rep_i = 4'd3;
        model_frame(1, 4, 100, 1, 3);
        drive_line(4, 100, 1'b1, 1'b0);
        begin
            int n;
            n = 0;
            while (beats < 6 && n < 200) begin @(negedge clk_i); n++; end
            chk("pre_reset_beats", 64'(beats), 6);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_tvalid", video_o_tvalid, 0);
        chk("mid_rst_side", {video_o_tuser, video_o_tlast, video_i_tready}, 0);
        chk("mid_rst_tdata", video_o_tdata, 0);
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        beats = 0;
        @(posedge clk_i); #1;
        px_rep_i = 4'd2; ln_rep_i = 4'd2;
        model_frame(2, 2, 200, 2, 2);
        drive_line(2, 200, 1'b1, 1'b0);
        drive_line(2, 202, 1'b0, 1'b0);
        wait_done(16, 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
